// File: rtl/ni_flit_injector.sv
// ni_flit_injector: network-interface transmitter for a router LOCAL_PORT input.
// Accepts whole packets (dst x/y + two payload words) and streams them out as
// HEAD, BODY, BODY, TAIL flits over a req/ack link. One packet can wait behind
// the active one, so back-to-back packets stream without idle cycles.
// Optional statistics counters are built only when NI_INJ_STATS_EN is defined.
module ni_flit_injector #(
    parameter int FLIT_SIZE = 19,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [ADDR_BITS-1:0] dst_x_i,
    input  logic [ADDR_BITS-1:0] dst_y_i,
    input  logic [DATA_BITS-1:0] data0_i,
    input  logic [DATA_BITS-1:0] data1_i,
    output logic [FLIT_SIZE-1:0] flit_o,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic [STAT_W-1:0]    pkt_sent_cnt_o,
    output logic [STAT_W-1:0]    stall_cnt_o
);

    // Packet storage layout: {dst_x, dst_y, data0, data1}
    localparam int PKT_W = 2 * ADDR_BITS + 2 * DATA_BITS;

    // Flit type codes (bits just below the valid bit)
    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;
    localparam logic [1:0] TYPE_NONE = 2'b11;

    localparam logic [FLIT_SIZE-1:0] NONE_FLIT = {1'b0, TYPE_NONE, {DATA_BITS{1'b0}}};
    localparam logic [FLIT_SIZE-1:0] TAIL_FLIT = {1'b1, TYPE_TAIL, {DATA_BITS{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY1,
        ST_BODY2,
        ST_TAIL
    } state_t;

    state_t               state_reg;
    logic                 req_reg;
    logic [FLIT_SIZE-1:0] flit_reg;
    logic                 ready_reg;
    logic                 busy_reg;

    logic                 act_full_reg,  act_full_next;
    logic [PKT_W-1:0]     act_pkt_reg,   act_pkt_next;
    logic                 pend_full_reg, pend_full_next;
    logic [PKT_W-1:0]     pend_pkt_reg,  pend_pkt_next;

    logic                 accept;
    logic                 xfer;
    logic                 tail_xfer;
    logic [PKT_W-1:0]     in_pkt;

    function automatic logic [FLIT_SIZE-1:0] head_flit(input logic [ADDR_BITS-1:0] x,
                                                       input logic [ADDR_BITS-1:0] y);
        return {1'b1, TYPE_HEAD, x, y};
    endfunction

    function automatic logic [FLIT_SIZE-1:0] body_flit(input logic [DATA_BITS-1:0] d);
        return {1'b1, TYPE_BODY, d};
    endfunction

    assign accept    = pkt_valid_i && ready_reg;
    assign xfer      = req_reg && ack_i;
    assign tail_xfer = xfer && (state_reg == ST_TAIL);
    assign in_pkt    = {dst_x_i, dst_y_i, data0_i, data1_i};

    // Next occupancy of the active/pending slots; pending promotes on tail transfer
    always_comb begin
        act_full_next  = act_full_reg;
        act_pkt_next   = act_pkt_reg;
        pend_full_next = pend_full_reg;
        pend_pkt_next  = pend_pkt_reg;
        if (tail_xfer) begin
            if (pend_full_reg) begin
                act_pkt_next   = pend_pkt_reg;
                pend_full_next = 1'b0;
            end else if (accept) begin
                act_pkt_next = in_pkt;
            end else begin
                act_full_next = 1'b0;
            end
        end else if (accept) begin
            if (!act_full_reg) begin
                act_full_next = 1'b1;
                act_pkt_next  = in_pkt;
            end else begin
                pend_full_next = 1'b1;
                pend_pkt_next  = in_pkt;
            end
        end
    end

    // Packet slot registers plus registered ready/busy derived from next occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_full_reg  <= 1'b0;
            act_pkt_reg   <= '0;
            pend_full_reg <= 1'b0;
            pend_pkt_reg  <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            act_full_reg  <= act_full_next;
            act_pkt_reg   <= act_pkt_next;
            pend_full_reg <= pend_full_next;
            pend_pkt_reg  <= pend_pkt_next;
            ready_reg     <= !pend_full_next;
            busy_reg      <= act_full_next || pend_full_next;
        end
    end

    // Flit sequencer: advances only on transfer, chains straight into the next head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            req_reg   <= 1'b0;
            flit_reg  <= NONE_FLIT;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (act_full_reg) begin
                        state_reg <= ST_HEAD;
                        req_reg   <= 1'b1;
                        flit_reg  <= head_flit(act_pkt_reg[PKT_W-1 -: ADDR_BITS],
                                               act_pkt_reg[2*DATA_BITS +: ADDR_BITS]);
                    end
                end
                ST_HEAD: begin
                    if (xfer) begin
                        state_reg <= ST_BODY1;
                        flit_reg  <= body_flit(act_pkt_reg[DATA_BITS +: DATA_BITS]);
                    end
                end
                ST_BODY1: begin
                    if (xfer) begin
                        state_reg <= ST_BODY2;
                        flit_reg  <= body_flit(act_pkt_reg[0 +: DATA_BITS]);
                    end
                end
                ST_BODY2: begin
                    if (xfer) begin
                        state_reg <= ST_TAIL;
                        flit_reg  <= TAIL_FLIT;
                    end
                end
                ST_TAIL: begin
                    if (xfer) begin
                        if (pend_full_reg) begin
                            state_reg <= ST_HEAD;
                            flit_reg  <= head_flit(pend_pkt_reg[PKT_W-1 -: ADDR_BITS],
                                                   pend_pkt_reg[2*DATA_BITS +: ADDR_BITS]);
                        end else if (accept) begin
                            state_reg <= ST_HEAD;
                            flit_reg  <= head_flit(dst_x_i, dst_y_i);
                        end else begin
                            state_reg <= ST_IDLE;
                            req_reg   <= 1'b0;
                            flit_reg  <= NONE_FLIT;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                    flit_reg  <= NONE_FLIT;
                end
            endcase
        end
    end

    assign flit_o      = flit_reg;
    assign req_o       = req_reg;
    assign pkt_ready_o = ready_reg;
    assign busy_o      = busy_reg;

`ifdef NI_INJ_STATS_EN
    logic [STAT_W-1:0] sent_cnt_reg;
    logic [STAT_W-1:0] stall_cnt_reg;

    // Saturating counters for completed packets and backpressured cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sent_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (tail_xfer && (sent_cnt_reg != '1)) begin
                sent_cnt_reg <= sent_cnt_reg + 1'b1;
            end
            if (req_reg && !ack_i && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign pkt_sent_cnt_o = sent_cnt_reg;
    assign stall_cnt_o    = stall_cnt_reg;
`else
    assign pkt_sent_cnt_o = '0;
    assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_ni_flit_injector.sv
// Testbench for ni_flit_injector: scoreboard of expected flits filled on packet
// acceptance, drained by a transfer monitor that runs once per clock cycle.
module tb_ni_flit_injector;

    localparam int FLIT_SIZE = 19;
    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 16;
    localparam int STAT_W    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pkt_valid_i;
    logic                 pkt_ready_o;
    logic [ADDR_BITS-1:0] dst_x_i;
    logic [ADDR_BITS-1:0] dst_y_i;
    logic [DATA_BITS-1:0] data0_i;
    logic [DATA_BITS-1:0] data1_i;
    logic [FLIT_SIZE-1:0] flit_o;
    logic                 req_o;
    logic                 ack_i;
    logic                 busy_o;
    logic [STAT_W-1:0]    pkt_sent_cnt_o;
    logic [STAT_W-1:0]    stall_cnt_o;

    ni_flit_injector #(
        .FLIT_SIZE(FLIT_SIZE),
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .STAT_W   (STAT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt_valid_i   (pkt_valid_i),
        .pkt_ready_o   (pkt_ready_o),
        .dst_x_i       (dst_x_i),
        .dst_y_i       (dst_y_i),
        .data0_i       (data0_i),
        .data1_i       (data1_i),
        .flit_o        (flit_o),
        .req_o         (req_o),
        .ack_i         (ack_i),
        .busy_o        (busy_o),
        .pkt_sent_cnt_o(pkt_sent_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    logic [FLIT_SIZE-1:0] exp_q[$];
    int                   xfer_log[$];
    int                   n_vec  = 0;
    int                   n_fail = 0;
    int                   cyc    = 0;
    logic                 rand_ack = 1'b0;
    logic                 prev_hold = 1'b0;
    logic [FLIT_SIZE-1:0] prev_flit = '0;

`ifdef NI_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // One clock cycle: check the pending transfer/hold at negedge, return at posedge+1
    task automatic step();
        logic [FLIT_SIZE-1:0] e;
        @(negedge clk);
        if (rst_n && prev_hold) begin
            n_vec++;
            if (req_o !== 1'b1 || flit_o !== prev_flit) begin
                n_fail++;
                $display("FAIL hold_stable cyc=%0d got req=%b flit=%h need req=1 flit=%h",
                         cyc, req_o, flit_o, prev_flit);
            end
        end
        if (rst_n && req_o && ack_i) begin
            n_vec++;
            xfer_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_flit cyc=%0d got %h need none", cyc, flit_o);
            end else begin
                e = exp_q.pop_front();
                if (flit_o !== e) begin
                    n_fail++;
                    $display("FAIL flit cyc=%0d got %h need %h", cyc, flit_o, e);
                end else begin
                    $display("xfer cyc=%0d flit=%h", cyc, flit_o);
                end
            end
        end
        prev_hold = rst_n && req_o && !ack_i;
        prev_flit = flit_o;
        cyc++;
        @(posedge clk);
        #1;
        if (rand_ack) ack_i = 1'($urandom_range(0, 1));
    endtask

    // Offer one packet until accepted; expected flits go to the scoreboard
    task automatic offer(input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] d0, input logic [15:0] d1, output int waits);
        logic rdy;
        waits       = 0;
        pkt_valid_i = 1'b1;
        dst_x_i = x; dst_y_i = y; data0_i = d0; data1_i = d1;
        while (1) begin
            rdy = pkt_ready_o;
            step();
            if (rdy) break;
            waits++;
            if (waits > 200) begin
                n_vec++; n_fail++;
                $display("FAIL accept_timeout got waits=%0d need <=200", waits);
                break;
            end
        end
        if (waits <= 200) begin
            exp_q.push_back({1'b1, 2'b00, x, y});
            exp_q.push_back({1'b1, 2'b10, d0});
            exp_q.push_back({1'b1, 2'b10, d1});
            exp_q.push_back({1'b1, 2'b01, 16'h0000});
            $display("pkt accepted x=%h y=%h d0=%h d1=%h waits=%0d", x, y, d0, d1, waits);
        end
        pkt_valid_i = 1'b0;
        dst_x_i = 8'($urandom); dst_y_i = 8'($urandom);
        data0_i = 16'($urandom); data1_i = 16'($urandom);
    endtask

    // Run until scoreboard empty and link idle, then check the idle outputs
    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !req_o) && n < 300) begin
            step();
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0 || req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain got left=%0d req=%b need left=0 req=0", name, exp_q.size(), req_o);
            exp_q.delete();
        end
        n_vec++;
        if (flit_o !== 19'h30000 || busy_o !== 1'b0 || pkt_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle got flit=%h busy=%b ready=%b need 30000/0/1",
                     name, flit_o, busy_o, pkt_ready_o);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if (req_o !== 1'b0 || flit_o !== 19'h30000 || pkt_ready_o !== 1'b1 || busy_o !== 1'b0 ||
            pkt_sent_cnt_o !== '0 || stall_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL %s got req=%b flit=%h ready=%b busy=%b sent=%0d stall=%0d need 0/30000/1/0/0/0",
                     name, req_o, flit_o, pkt_ready_o, busy_o, pkt_sent_cnt_o, stall_cnt_o);
        end else begin
            $display("%s ok", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pkt_valid_i = 1'b0; ack_i = 1'b0;
        dst_x_i = '0; dst_y_i = '0; data0_i = '0; data1_i = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int w;
        logic [STAT_W-1:0] s0;
        s0 = pkt_sent_cnt_o;
        ack_i = 1'b1;
        offer(8'h12, 8'h34, 16'hBEEF, 16'hCAFE, w);
        n_vec++;
        if (req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency0 got req=%b busy=%b need req=0 busy=1", req_o, busy_o);
        end
        step();
        n_vec++;
        if (req_o !== 1'b1 || flit_o !== 19'h41234) begin
            n_fail++;
            $display("FAIL single_head got req=%b flit=%h need 1 41234", req_o, flit_o);
        end
        xfer_log.delete();
        drain("single");
        n_vec++;
        if (xfer_log.size() != 4 || (xfer_log[3] - xfer_log[0]) != 3) begin
            n_fail++;
            $display("FAIL single_contig got n=%0d need 4 consecutive", xfer_log.size());
        end
        n_vec++;
        if (pkt_sent_cnt_o !== (STATS ? s0 + 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL single_sent_cnt got %0d need %0d", pkt_sent_cnt_o, STATS ? s0 + 16'd1 : 16'd0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [STAT_W-1:0] st0;
        st0 = stall_cnt_o;
        ack_i = 1'b1;
        offer(8'h12, 8'h34, 16'hBEEF, 16'hCAFE, w);
        step();          // HEAD shown, transfers at next edge
        step();          // BODY1 shown
        ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (req_o !== 1'b1 || flit_o !== 19'h6BEEF) begin
                n_fail++;
                $display("FAIL bp_hold%0d got req=%b flit=%h need 1 6beef", i, req_o, flit_o);
            end
        end
        ack_i = 1'b1;
        drain("backpressure");
        n_vec++;
        if (stall_cnt_o !== (STATS ? st0 + 16'd3 : 16'd0)) begin
            n_fail++;
            $display("FAIL bp_stall_cnt got %0d need %0d", stall_cnt_o, STATS ? st0 + 16'd3 : 16'd0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [STAT_W-1:0] s0;
        s0 = pkt_sent_cnt_o;
        ack_i = 1'b1;
        xfer_log.delete();
        offer(8'h01, 8'h02, 16'h1111, 16'h2222, w);
        offer(8'h03, 8'h04, 16'h3333, 16'h4444, w);
        n_vec++;
        if (pkt_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready got ready=%b busy=%b need 0 1", pkt_ready_o, busy_o);
        end
        drain("b2b");
        n_vec++;
        if (xfer_log.size() != 8 || (xfer_log[7] - xfer_log[0]) != 7) begin
            n_fail++;
            $display("FAIL b2b_gapless got n=%0d need 8 consecutive", xfer_log.size());
        end
        n_vec++;
        if (pkt_sent_cnt_o !== (STATS ? s0 + 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL b2b_sent_cnt got %0d need %0d", pkt_sent_cnt_o, STATS ? s0 + 16'd2 : 16'd0);
        end
    endtask

    task automatic test_pending_full();
        int w;
        ack_i = 1'b1;
        xfer_log.delete();
        offer(8'hA1, 8'hB1, 16'h0A01, 16'h0B01, w);
        offer(8'hA2, 8'hB2, 16'h0A02, 16'h0B02, w);
        offer(8'hA3, 8'hB3, 16'h0A03, 16'h0B03, w);
        n_vec++;
        if (w != 4) begin
            n_fail++;
            $display("FAIL pend_wait got %0d need 4", w);
        end
        drain("pending");
        n_vec++;
        if (xfer_log.size() != 12 || (xfer_log[11] - xfer_log[0]) != 11) begin
            n_fail++;
            $display("FAIL pend_gapless got n=%0d need 12 consecutive", xfer_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int w;
        ack_i = 1'b1;
        offer(8'h55, 8'h66, 16'h7777, 16'h8888, w);
        step();          // HEAD shown
        step();          // HEAD transferred, BODY1 shown
        rst_n = 1'b0;
        ack_i = 1'b0;
        step();
        check_idle_outputs("reset_mid");
        exp_q.delete();
        rst_n = 1'b1;
        ack_i = 1'b1;
        step();
        offer(8'h9A, 8'hBC, 16'h1357, 16'h2468, w);
        step();
        n_vec++;
        if (req_o !== 1'b1 || flit_o !== 19'h49ABC) begin
            n_fail++;
            $display("FAIL reset_mid_restart got req=%b flit=%h need 1 49abc", req_o, flit_o);
        end
        drain("reset_mid");
    endtask

    task automatic test_idle_ack();
        logic [STAT_W-1:0] s0, st0;
        s0 = pkt_sent_cnt_o; st0 = stall_cnt_o;
        ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (req_o !== 1'b0 || flit_o !== 19'h30000) begin
                n_fail++;
                $display("FAIL idle_ack%0d got req=%b flit=%h need 0 30000", i, req_o, flit_o);
            end
        end
        n_vec++;
        if (pkt_sent_cnt_o !== s0 || stall_cnt_o !== st0) begin
            n_fail++;
            $display("FAIL idle_counters got %0d/%0d need %0d/%0d", pkt_sent_cnt_o, stall_cnt_o, s0, st0);
        end
    endtask

    task automatic test_random_ack();
        int w;
        rand_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), w);
        end
        rand_ack = 1'b0;
        ack_i = 1'b1;
        drain("random_ack");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_pending_full();
        test_idle_ack();
        test_reset_mid();
        test_random_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
